// File: rtl/execute_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : execute_stage (with execute_stage_pkg)                        |
// | Purpose  : EX stage of a 5-stage MIPS pipeline. Registers the decode     |
// |            bundle, evaluates the ALU combinationally, owns HI/LO and a   |
// |            multi-cycle MULT/DIV unit, and stalls upstream while a        |
// |            multiply/divide is in flight.                                 |
// | Ports    : clk, reset            - clock, synchronous active-high reset  |
// |            execute_enable        - 1 latch decode bundle, 0 latch bubble |
// |            decode_data_reg       - decode_data_t from ID                 |
// |            execute_data_reg      - execute_data_t to MEM                 |
// |            execute_stall         - hold upstream stages                  |
// |            hi_out, lo_out        - current HI/LO                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

package execute_stage_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [4:0]  alu_op;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] imm;
  } decode_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic [31:0] alu_result;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } execute_data_t;

  // ALU_NOP is zero so an all-zero bubble decodes as a harmless no-op.
  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_ADDU  = 5'd2;
  localparam logic [4:0] ALU_SUB   = 5'd3;
  localparam logic [4:0] ALU_SUBU  = 5'd4;
  localparam logic [4:0] ALU_AND   = 5'd5;
  localparam logic [4:0] ALU_OR    = 5'd6;
  localparam logic [4:0] ALU_XOR   = 5'd7;
  localparam logic [4:0] ALU_NOR   = 5'd8;
  localparam logic [4:0] ALU_SLT   = 5'd9;
  localparam logic [4:0] ALU_SLTU  = 5'd10;
  localparam logic [4:0] ALU_SLL   = 5'd11;
  localparam logic [4:0] ALU_SRL   = 5'd12;
  localparam logic [4:0] ALU_SRA   = 5'd13;
  localparam logic [4:0] ALU_SLLV  = 5'd14;
  localparam logic [4:0] ALU_SRLV  = 5'd15;
  localparam logic [4:0] ALU_SRAV  = 5'd16;
  localparam logic [4:0] ALU_LUI   = 5'd17;
  localparam logic [4:0] ALU_MFHI  = 5'd18;
  localparam logic [4:0] ALU_MFLO  = 5'd19;
  localparam logic [4:0] ALU_MTHI  = 5'd20;
  localparam logic [4:0] ALU_MTLO  = 5'd21;
  localparam logic [4:0] ALU_MULT  = 5'd22;
  localparam logic [4:0] ALU_MULTU = 5'd23;
  localparam logic [4:0] ALU_DIV   = 5'd24;
  localparam logic [4:0] ALU_DIVU  = 5'd25;

endpackage

module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int          MUL_CYCLES = 4,      // cycles in MUL state, 1..64
  parameter logic [31:0] HILO_RESET = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          execute_enable,
  input  decode_data_t  decode_data_reg,
  output execute_data_t execute_data_reg,
  output logic          execute_stall,
  output logic [31:0]   hi_out,
  output logic [31:0]   lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] c_MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] c_DIV_LOAD = 6'd31;

  decode_data_t data_q;
  logic [1:0]   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [31:0]  hi_q, lo_q;

  // Captured muldiv operands and restoring-divider working registers.
  logic [31:0]  md_a_q, md_b_q;
  logic         md_signed_q, md_div_q;
  logic [31:0]  div_rem_q, div_quo_q, div_dvs_q;

  logic         w_is_mul, w_is_div, w_is_md, w_op_signed;
  logic [31:0]  w_b, w_alu;
  logic [4:0]   w_shamt;
  logic [31:0]  w_abs_a, w_abs_b;
  logic [32:0]  w_shift;
  logic         w_ge;
  logic [31:0]  w_diff;
  logic [63:0]  w_ext_a, w_ext_b, w_prod;
  logic [31:0]  w_quo_fix, w_rem_fix, w_div_hi, w_div_lo;

  assign w_is_mul    = (data_q.alu_op == ALU_MULT) || (data_q.alu_op == ALU_MULTU);
  assign w_is_div    = (data_q.alu_op == ALU_DIV)  || (data_q.alu_op == ALU_DIVU);
  assign w_is_md     = w_is_mul || w_is_div;
  assign w_op_signed = (data_q.alu_op == ALU_MULT) || (data_q.alu_op == ALU_DIV);

  // ---------------- muldiv FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- muldiv FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_is_mul) begin
          state_d = S_MUL;
          cnt_d   = c_MUL_LOAD;
        end else if (w_is_div) begin
          state_d = S_DIV;
          cnt_d   = c_DIV_LOAD;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == 6'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      default: state_d = S_IDLE;  // S_DONE
    endcase
  end

  // ---------------- muldiv FSM: outputs ----------------
  // The IDLE cycle with a muldiv op already stalls, so upstream holds
  // from the first cycle the op occupies the stage.
  always_comb begin
    execute_stall = 1'b0;
    case (state_q)
      S_IDLE:       execute_stall = w_is_md;
      S_MUL, S_DIV: execute_stall = 1'b1;
      default:      execute_stall = 1'b0;
    endcase
  end

  // ---------------- input register ----------------
  always_ff @(posedge clk) begin
    if (reset)               data_q <= '0;
    else if (execute_stall)  data_q <= data_q;
    else if (execute_enable) data_q <= decode_data_reg;
    else                     data_q <= '0;
  end

  // ---------------- divider datapath ----------------
  assign w_abs_a = (w_op_signed && data_q.src_a[31]) ? (32'd0 - data_q.src_a) : data_q.src_a;
  assign w_abs_b = (w_op_signed && data_q.src_b[31]) ? (32'd0 - data_q.src_b) : data_q.src_b;

  // Partial remainder never reaches 2^32 after a step, so the 32-bit
  // difference is exact whenever the trial subtraction succeeds.
  assign w_shift = {div_rem_q, div_quo_q[31]};
  assign w_ge    = (w_shift >= {1'b0, div_dvs_q});
  assign w_diff  = w_shift[31:0] - div_dvs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_a_q      <= '0;
      md_b_q      <= '0;
      md_signed_q <= 1'b0;
      md_div_q    <= 1'b0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_dvs_q   <= '0;
    end else if (state_q == S_IDLE && w_is_md) begin
      md_a_q      <= data_q.src_a;
      md_b_q      <= data_q.src_b;
      md_signed_q <= w_op_signed;
      md_div_q    <= w_is_div;
      div_rem_q   <= '0;
      div_quo_q   <= w_abs_a;
      div_dvs_q   <= w_abs_b;
    end else if (state_q == S_DIV) begin
      div_rem_q <= w_ge ? w_diff : w_shift[31:0];
      div_quo_q <= {div_quo_q[30:0], w_ge};
    end
  end

  // Sign-extend (or zero-extend) to 64 bits; the low 64 bits of the
  // product are then correct for both signed and unsigned forms.
  assign w_ext_a = {{32{md_signed_q & md_a_q[31]}}, md_a_q};
  assign w_ext_b = {{32{md_signed_q & md_b_q[31]}}, md_b_q};
  assign w_prod  = w_ext_a * w_ext_b;

  assign w_quo_fix = (md_signed_q && (md_a_q[31] ^ md_b_q[31])) ? (32'd0 - div_quo_q) : div_quo_q;
  assign w_rem_fix = (md_signed_q && md_a_q[31]) ? (32'd0 - div_rem_q) : div_rem_q;
  // Divide by zero: quotient all ones, remainder is the raw dividend.
  assign w_div_lo  = (md_b_q == 32'd0) ? 32'hFFFF_FFFF : w_quo_fix;
  assign w_div_hi  = (md_b_q == 32'd0) ? md_a_q        : w_rem_fix;

  // ---------------- HI / LO ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= HILO_RESET;
      lo_q <= HILO_RESET;
    end else if (state_q == S_DONE) begin
      if (md_div_q) begin
        hi_q <= w_div_hi;
        lo_q <= w_div_lo;
      end else begin
        hi_q <= w_prod[63:32];
        lo_q <= w_prod[31:0];
      end
    end else if (data_q.alu_op == ALU_MTHI) begin
      hi_q <= data_q.src_a;
    end else if (data_q.alu_op == ALU_MTLO) begin
      lo_q <= data_q.src_a;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

  // ---------------- ALU ----------------
  assign w_b     = data_q.alu_src ? data_q.imm : data_q.src_b;
  assign w_shamt = data_q.instruction[10:6];

  always_comb begin
    w_alu = '0;
    case (data_q.alu_op)
      ALU_ADD, ALU_ADDU: w_alu = data_q.src_a + w_b;
      ALU_SUB, ALU_SUBU: w_alu = data_q.src_a - w_b;
      ALU_AND:  w_alu = data_q.src_a & w_b;
      ALU_OR:   w_alu = data_q.src_a | w_b;
      ALU_XOR:  w_alu = data_q.src_a ^ w_b;
      ALU_NOR:  w_alu = ~(data_q.src_a | w_b);
      ALU_SLT:  w_alu = {31'd0, $signed(data_q.src_a) < $signed(w_b)};
      ALU_SLTU: w_alu = {31'd0, data_q.src_a < w_b};
      ALU_SLL:  w_alu = w_b << w_shamt;
      ALU_SRL:  w_alu = w_b >> w_shamt;
      ALU_SRA:  w_alu = $signed(w_b) >>> w_shamt;
      ALU_SLLV: w_alu = w_b << data_q.src_a[4:0];
      ALU_SRLV: w_alu = w_b >> data_q.src_a[4:0];
      ALU_SRAV: w_alu = $signed(w_b) >>> data_q.src_a[4:0];
      ALU_LUI:  w_alu = {data_q.imm[15:0], 16'h0000};
      ALU_MFHI: w_alu = hi_q;
      ALU_MFLO: w_alu = lo_q;
      default:  w_alu = '0;
    endcase
  end

  // ---------------- output bundle ----------------
  // Bubble while stalled so MEM never sees the muldiv op twice.
  always_comb begin
    execute_data_reg = '0;
    if (!execute_stall) begin
      execute_data_reg.pc          = data_q.pc;
      execute_data_reg.instruction = data_q.instruction;
      execute_data_reg.mem_to_reg  = data_q.mem_to_reg;
      execute_data_reg.reg_dst     = data_q.reg_dst;
      execute_data_reg.reg_write   = data_q.reg_write & ~w_is_md;
      execute_data_reg.alu_result  = w_alu;
      execute_data_reg.rs          = data_q.rs;
      execute_data_reg.rt          = data_q.rt;
      execute_data_reg.rd          = data_q.rd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_execute_stage                                              |
// | Purpose  : Self-checking bench for execute_stage: ALU vector table with  |
// |            a result scoreboard, plus MULT/DIV, reset and enable cases.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          execute_enable;
  decode_data_t  decode_data_reg;
  execute_data_t execute_data_reg;
  logic          execute_stall;
  logic [31:0]   hi_out, lo_out;

  always #5 clk = ~clk;

  execute_stage #(.MUL_CYCLES(4), .HILO_RESET(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .execute_enable   (execute_enable),
    .decode_data_reg  (decode_data_reg),
    .execute_data_reg (execute_data_reg),
    .execute_stall    (execute_stall),
    .hi_out           (hi_out),
    .lo_out           (lo_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a, b, imm, instr;
    logic        alu_src;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        chk;
    logic [31:0] res;
  } alu_exp_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    int          stall;
    logic [31:0] hi, lo;
  } md_exp_t;

  vec_t     vt[$];
  alu_exp_t alu_q[$];
  md_exp_t  md_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic decode_data_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] imm, input logic [31:0] instr,
                                      input logic alu_src, input logic [31:0] pc);
    decode_data_t d;
    d = '0;
    d.pc = pc; d.instruction = instr; d.alu_op = op; d.alu_src = alu_src;
    d.reg_write = 1'b1; d.reg_dst = 1'b1;
    d.rs = 5'd1; d.rt = 5'd2; d.rd = 5'd3;
    d.src_a = a; d.src_b = b; d.imm = imm;
    return d;
  endfunction

  function automatic vec_t mkv(input string n, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm, input logic [31:0] instr,
                               input logic src, input logic chk, input logic [31:0] exp);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.imm = imm; v.instr = instr;
    v.alu_src = src; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic md_expect(input string n, input logic [31:0] pc, input int stall,
                           input logic [31:0] hi, input logic [31:0] lo);
    md_exp_t e;
    e.name = n; e.pc = pc; e.stall = stall; e.hi = hi; e.lo = lo;
    md_q.push_back(e);
  endtask

  // Entered at #1 after the edge that latched a muldiv op; leaves at #1
  // after the DONE edge, with `nxt` latched into the stage.
  task automatic md_run(input decode_data_t nxt);
    md_exp_t e;
    int      n;
    logic    bub_ok;
    e = md_q.pop_front();
    decode_data_reg = nxt;
    n = 0;
    bub_ok = 1'b1;
    while (execute_stall && n < 100) begin
      if (execute_data_reg !== '0) bub_ok = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    check({e.name, " stall cycles"}, n, e.stall);
    check({e.name, " bubble while stalled"}, {31'd0, bub_ok}, 32'd1);
    check({e.name, " DONE pc"}, execute_data_reg.pc, e.pc);
    check({e.name, " DONE reg_write"}, {31'd0, execute_data_reg.reg_write}, 32'd0);
    @(posedge clk); #1;
    check({e.name, " HI"}, hi_out, e.hi);
    check({e.name, " LO"}, lo_out, e.lo);
  endtask

  initial begin
    alu_exp_t ae;

    // ---------------- vector table ----------------
    vt.push_back(mkv("ADD",   ALU_ADD,  32'd7,         32'hFFFF_FFFD, 32'h0,    32'h0,   1'b0, 1'b1, 32'd4));
    vt.push_back(mkv("SUB",   ALU_SUB,  32'd5,         32'd9,         32'h0,    32'h0,   1'b0, 1'b1, 32'hFFFF_FFFC));
    vt.push_back(mkv("AND",   ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,    32'h0,   1'b0, 1'b1, 32'hF000_F000));
    vt.push_back(mkv("OR",    ALU_OR,   32'hF0F0_0000, 32'h0000_0F0F, 32'h0,    32'h0,   1'b0, 1'b1, 32'hF0F0_0F0F));
    vt.push_back(mkv("XOR",   ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0,    32'h0,   1'b0, 1'b1, 32'hF0F0_0F0F));
    vt.push_back(mkv("NOR",   ALU_NOR,  32'h0000_00FF, 32'h0000_FF00, 32'h0,    32'h0,   1'b0, 1'b1, 32'hFFFF_0000));
    vt.push_back(mkv("SLT",   ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'h0,    32'h0,   1'b0, 1'b1, 32'd1));
    vt.push_back(mkv("SLTU",  ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h0,    32'h0,   1'b0, 1'b1, 32'd0));
    vt.push_back(mkv("SRA",   ALU_SRA,  32'h0,         32'h8000_0000, 32'h0,    32'h100, 1'b0, 1'b1, 32'hF800_0000));
    vt.push_back(mkv("SRL",   ALU_SRL,  32'h0,         32'h8000_0000, 32'h0,    32'h100, 1'b0, 1'b1, 32'h0800_0000));
    vt.push_back(mkv("SLL",   ALU_SLL,  32'h0,         32'd1,         32'h0,    32'h7C0, 1'b0, 1'b1, 32'h8000_0000));
    vt.push_back(mkv("SLLV",  ALU_SLLV, 32'h23,        32'd1,         32'h0,    32'h0,   1'b0, 1'b1, 32'd8));
    vt.push_back(mkv("SRLV",  ALU_SRLV, 32'd4,         32'h0000_FF00, 32'h0,    32'h0,   1'b0, 1'b1, 32'h0000_0FF0));
    vt.push_back(mkv("SRAV",  ALU_SRAV, 32'd8,         32'hF000_0000, 32'h0,    32'h0,   1'b0, 1'b1, 32'hFFF0_0000));
    vt.push_back(mkv("LUI",   ALU_LUI,  32'h0,         32'h0,         32'h1234, 32'h0,   1'b1, 1'b1, 32'h1234_0000));
    vt.push_back(mkv("ADDUi", ALU_ADDU, 32'hFFFF_FFFF, 32'h55,        32'd1,    32'h0,   1'b1, 1'b1, 32'd0));
    vt.push_back(mkv("MTHI",  ALU_MTHI, 32'hDEAD_BEEF, 32'h0,         32'h0,    32'h0,   1'b0, 1'b0, 32'h0));
    vt.push_back(mkv("MFHI",  ALU_MFHI, 32'h0,         32'h0,         32'h0,    32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF));
    vt.push_back(mkv("MTLO",  ALU_MTLO, 32'h1234_5678, 32'h0,         32'h0,    32'h0,   1'b0, 1'b0, 32'h0));
    vt.push_back(mkv("MFLO",  ALU_MFLO, 32'h0,         32'h0,         32'h0,    32'h0,   1'b0, 1'b1, 32'h1234_5678));

    // ---------------- reset state ----------------
    reset = 1'b1;
    execute_enable = 1'b0;
    decode_data_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out", {31'd0, execute_data_reg !== '0}, 32'd0);
    check("reset stall", {31'd0, execute_stall}, 32'd0);
    check("reset HI", hi_out, 32'h0);
    check("reset LO", lo_out, 32'h0);
    reset = 1'b0;
    execute_enable = 1'b1;

    // ---------------- ALU table through scoreboard ----------------
    foreach (vt[i]) begin
      decode_data_reg = mk(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].instr, vt[i].alu_src, 32'h1000 + 32'(i * 4));
      ae.name = vt[i].name; ae.pc = 32'h1000 + 32'(i * 4); ae.chk = vt[i].chk; ae.res = vt[i].exp;
      alu_q.push_back(ae);
      @(posedge clk); #1;
      ae = alu_q.pop_front();
      check({ae.name, " stall"}, {31'd0, execute_stall}, 32'd0);
      check({ae.name, " pc"}, execute_data_reg.pc, ae.pc);
      if (ae.chk) check({ae.name, " result"}, execute_data_reg.alu_result, ae.res);
    end
    check("passthru rd", {27'd0, execute_data_reg.rd}, 32'd3);
    check("passthru reg_write", {31'd0, execute_data_reg.reg_write}, 32'd1);

    // ---------------- execute_enable low: two bubbles ----------------
    decode_data_reg = mk(ALU_ADD, 32'd1, 32'd2, 32'h0, 32'h0, 1'b0, 32'h2000);
    execute_enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("enable0 bubble", {31'd0, execute_data_reg !== '0}, 32'd0);
    end
    execute_enable = 1'b1;

    // ---------------- MULT then MFLO ----------------
    md_expect("MULT", 32'h3000, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    decode_data_reg = mk(ALU_MULT, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 1'b0, 32'h3000);
    @(posedge clk); #1;
    md_run(mk(ALU_MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h3004));
    check("MFLO after MULT", execute_data_reg.alu_result, 32'hFFFF_FFFE);
    check("MFLO after MULT stall", {31'd0, execute_stall}, 32'd0);

    // ---------------- MULTU followed back-to-back by DIVU ----------------
    md_expect("MULTU", 32'h3100, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    decode_data_reg = mk(ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 1'b0, 32'h3100);
    @(posedge clk); #1;
    md_expect("DIVU", 32'h3104, 33, 32'd2, 32'd14);
    md_run(mk(ALU_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 32'h3104));
    md_run('0);

    // ---------------- signed divides ----------------
    md_expect("DIV -7/2", 32'h3200, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    decode_data_reg = mk(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b0, 32'h3200);
    @(posedge clk); #1;
    md_run('0);

    md_expect("DIV 5/0", 32'h3300, 33, 32'd5, 32'hFFFF_FFFF);
    decode_data_reg = mk(ALU_DIV, 32'd5, 32'd0, 32'h0, 32'h0, 1'b0, 32'h3300);
    @(posedge clk); #1;
    md_run('0);

    md_expect("DIV 7/-2", 32'h3400, 33, 32'd1, 32'hFFFF_FFFD);
    decode_data_reg = mk(ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0, 32'h3400);
    @(posedge clk); #1;
    md_run('0);

    // ---------------- reset in the middle of a DIV ----------------
    decode_data_reg = mk(ALU_DIV, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0, 32'h3500);
    @(posedge clk); #1;
    decode_data_reg = '0;
    repeat (9) @(posedge clk);
    #1;
    check("midDIV still stalled", {31'd0, execute_stall}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midDIV reset stall", {31'd0, execute_stall}, 32'd0);
    check("midDIV reset out", {31'd0, execute_data_reg !== '0}, 32'd0);
    check("midDIV reset HI", hi_out, 32'h0);
    check("midDIV reset LO", lo_out, 32'h0);
    reset = 1'b0;
    decode_data_reg = mk(ALU_ADD, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'h0, 1'b0, 32'h3600);
    @(posedge clk); #1;
    check("ADD after reset stall", {31'd0, execute_stall}, 32'd0);
    check("ADD after reset result", execute_data_reg.alu_result, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
